// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one SPI flash port between two requesters (0: JTAG-to-SPI bridge,
//   1: fabric flash engine). Ownership is granted per transaction, ties are
//   resolved round-robin, and a chip-select-high guard interval separates
//   owners. A watchdog revokes a grant that is held for too long.
//
// Parameters
//   CSH_CYCLES  guard cycles with spi_cs_n forced high after a release (1..255)
//   TIMEOUT     maximum grant length in cycles, 0 disables the watchdog
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0/req1                level transaction requests
//   gnt0/gnt1                registered one-hot grants
//   cs0_n/sck0/mosi0 (and 1) requester SPI signals
//   miso0/miso1              flash data routed back to the owner only
//   spi_cs_n/spi_sck/spi_mosi/spi_miso  flash-side SPI pins
//   busy                     high while in GRANT or GUARD
//   owner                    current or last grantee
//   timeout_evt              one-cycle pulse when the watchdog revokes a grant
module spi_flash_arbiter #(
  parameter int unsigned CSH_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic cs0_n,
  input  logic cs1_n,
  input  logic sck0,
  input  logic sck1,
  input  logic mosi0,
  input  logic mosi1,
  output logic miso0,
  output logic miso1,
  output logic spi_cs_n,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic owner,
  output logic timeout_evt
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  lock_reg, lock_next;
  logic [7:0]  guard_reg, guard_next;
  logic [15:0] wd_reg, wd_next;
  logic        timeout_reg, timeout_next;

  logic [1:0] req, cs_n, sck, mosi, miso, eligible;
  logic       pick, wd_expire, granted;

  assign req  = {req1, req0};
  assign cs_n = {cs1_n, cs0_n};
  assign sck  = {sck1, sck0};
  assign mosi = {mosi1, mosi0};

  // TIMEOUT == 0 disables expiry entirely.
  assign wd_expire = (TIMEOUT != 0) && (wd_reg == 16'(TIMEOUT - 1));
  assign granted   = (state_reg == GRANT);

  // A requester revoked by the watchdog stays ineligible until it drops req.
  // Flash data is only returned to the current owner while granted.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign eligible[gi] = req[gi] & ~lock_reg[gi];
      assign miso[gi]     = (granted && (owner_reg == 1'(gi))) ? spi_miso : 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b1;
      gnt_reg     <= 2'b00;
      lock_reg    <= 2'b00;
      guard_reg   <= 8'd0;
      wd_reg      <= 16'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      gnt_reg     <= gnt_next;
      lock_reg    <= lock_next;
      guard_reg   <= guard_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    gnt_next     = gnt_reg;
    guard_next   = guard_reg;
    wd_next      = wd_reg;
    timeout_next = 1'b0;
    // Locks clear in any cycle the locked requester has req low.
    lock_next    = lock_reg & req;
    pick         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          // On a tie the requester that did not own the port last wins.
          pick       = (eligible == 2'b11) ? ~last_reg : eligible[1];
          owner_next = pick;
          last_next  = pick;
          gnt_next   = pick ? 2'b10 : 2'b01;
          wd_next    = 16'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        wd_next = wd_reg + 16'd1;
        if (!req[owner_reg] || wd_expire) begin
          state_next = GUARD;
          gnt_next   = 2'b00;
          guard_next = 8'(CSH_CYCLES - 1);
          if (wd_expire) begin
            timeout_next = 1'b1;
            // If req is already low the lock would clear this cycle anyway.
            lock_next[owner_reg] = req[owner_reg];
          end
        end
      end
      GUARD: begin
        if (guard_reg == 8'd0) begin
          state_next = IDLE;
        end else begin
          guard_next = guard_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data paths are purely combinational; outside GRANT the flash is parked
  // with chip select high, which also truncates any command still in flight.
  assign spi_cs_n    = granted ? cs_n[owner_reg] : 1'b1;
  assign spi_sck     = granted ? sck[owner_reg]  : 1'b0;
  assign spi_mosi    = granted ? mosi[owner_reg] : 1'b0;
  assign miso0       = miso[0];
  assign miso1       = miso[1];
  assign gnt0        = gnt_reg[0];
  assign gnt1        = gnt_reg[1];
  assign busy        = (state_reg != IDLE);
  assign owner       = owner_reg;
  assign timeout_evt = timeout_reg;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Testbench for spi_flash_arbiter with CSH_CYCLES = 4 and TIMEOUT = 100.
module tb_spi_flash_arbiter;

  localparam int CSH = 4;
  localparam int TMO = 100;

  logic clk, rst;
  logic req0, req1, gnt0, gnt1;
  logic cs0_n, cs1_n, sck0, sck1, mosi0, mosi1, miso0, miso1;
  logic spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic busy, owner, timeout_evt;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  spi_flash_arbiter #(.CSH_CYCLES(CSH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .cs0_n(cs0_n), .cs1_n(cs1_n), .sck0(sck0), .sck1(sck1),
    .mosi0(mosi0), .mosi1(mosi1), .miso0(miso0), .miso1(miso1),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .busy(busy), .owner(owner), .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until a grant appears; reports grantee and cycles taken.
  task automatic wait_rise(output int who, output int n, output bit ok);
    ok = 1'b0; who = -1; n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      n++;
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0;
    cs0_n = 0; cs1_n = 0; sck0 = 1; sck1 = 1; mosi0 = 1; mosi1 = 1; spi_miso = 1;
    #2;
    checks++; if ({gnt1, gnt0} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {gnt1, gnt0}); end
    checks++; if ({spi_cs_n, spi_sck, spi_mosi} !== 3'b100) begin failures++; $display("FAIL reset_spi got=%b exp=100", {spi_cs_n, spi_sck, spi_mosi}); end
    checks++; if ({miso1, miso0, busy, owner, timeout_evt} !== 5'b0) begin failures++; $display("FAIL reset_misc got=%b exp=00000", {miso1, miso0, busy, owner, timeout_evt}); end
    cs0_n = 1; cs1_n = 1; sck0 = 0; sck1 = 0; mosi0 = 0; mosi1 = 0; spi_miso = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_single();
    int who, n; bit ok;
    req1 = 1; exp_q.push_back(1);
    wait_rise(who, n, ok);
    checks++; if (!ok || who !== exp_q.pop_front()) begin failures++; $display("FAIL single_who got=%0d ok=%0d exp=1", who, ok); end
    checks++; if (n !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", n); end
    cs1_n = 0; sck1 = 1; mosi1 = 1; spi_miso = 1; #1;
    checks++; if ({spi_cs_n, spi_sck, spi_mosi, miso1, miso0} !== 5'b01110) begin failures++; $display("FAIL single_mux1 got=%b exp=01110", {spi_cs_n, spi_sck, spi_mosi, miso1, miso0}); end
    sck1 = 0; mosi1 = 0; spi_miso = 0; #1;
    checks++; if ({spi_cs_n, spi_sck, spi_mosi, miso1} !== 4'b0000) begin failures++; $display("FAIL single_mux0 got=%b exp=0000", {spi_cs_n, spi_sck, spi_mosi, miso1}); end
    for (int i = 0; i < 25; i++) tick();
    cs1_n = 1; tick();
    req1 = 0; tick();
    checks++; if ({gnt1, spi_cs_n} !== 2'b01) begin failures++; $display("FAIL single_release got=%b exp=01", {gnt1, spi_cs_n}); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy !== (i < CSH)) begin failures++; $display("FAIL single_guard_busy cyc=%0d got=%b exp=%b", i, busy, (i < CSH)); end
      tick();
    end
    $display("txn single: requester 1 granted latency=%0d", n);
  endtask

  task automatic test_contention();
    int who, n, cur; bit ok;
    req0 = 1; req1 = 1;
    exp_q.push_back(0); exp_q.push_back(1);
    wait_rise(who, n, ok);
    for (int k = 0; k < 4; k++) begin
      int exp_who;
      exp_who = exp_q.pop_front();
      checks++; if (!ok || who !== exp_who) begin failures++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, who, exp_who); end
      cur = who;
      for (int i = 0; i < 3; i++) tick();
      if (cur == 0) req0 = 0; else req1 = 0;
      tick();
      if (cur == 0) req0 = 1; else req1 = 1;
      exp_q.push_back(cur);
      wait_rise(who, n, ok);
      checks++; if (n !== CSH + 1) begin failures++; $display("FAIL rr_gap k=%0d got=%0d exp=%0d", k, n, CSH + 1); end
      $display("txn contention k=%0d granted=%0d gap=%0d", k, cur, n);
    end
    req0 = 0; req1 = 0;
    exp_q.delete();
    wait_idle();
  endtask

  task automatic test_watchdog();
    int who, n, hi, regrants; bit ok;
    req0 = 1; exp_q.push_back(0);
    wait_rise(who, n, ok);
    checks++; if (!ok || who !== exp_q.pop_front()) begin failures++; $display("FAIL wd_who got=%0d exp=0", who); end
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gnt0) hi++; else break;
    end
    checks++; if (hi !== TMO) begin failures++; $display("FAIL wd_len got=%0d exp=%0d", hi, TMO); end
    checks++; if (timeout_evt !== 1'b1) begin failures++; $display("FAIL wd_evt_on got=%b exp=1", timeout_evt); end
    tick();
    checks++; if (timeout_evt !== 1'b0) begin failures++; $display("FAIL wd_evt_off got=%b exp=0", timeout_evt); end
    regrants = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (gnt0) regrants++; end
    checks++; if (regrants !== 0) begin failures++; $display("FAIL wd_locked got=%0d exp=0", regrants); end
    req0 = 0; tick();
    req0 = 1; exp_q.push_back(0);
    wait_rise(who, n, ok);
    checks++; if (!ok || who !== exp_q.pop_front() || n !== 1) begin failures++; $display("FAIL wd_regrant who=%0d n=%0d exp=0/1", who, n); end
    $display("txn watchdog held=%0d regrant_latency=%0d", hi, n);
  endtask

  // Runs while requester 0 holds the grant from the watchdog test.
  task automatic test_isolation();
    logic [3:0] r;
    int bad;
    bad = 0;
    cs0_n = 0; spi_miso = 1;
    for (int i = 0; i < 8; i++) begin
      r = 4'($urandom);
      cs1_n = r[0]; sck1 = r[1]; mosi1 = r[2]; sck0 = r[3]; mosi0 = ~r[3];
      #1;
      if ({spi_cs_n, spi_sck, spi_mosi, miso1, miso0} !== {1'b0, r[3], ~r[3], 1'b0, 1'b1}) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL isolation bad_samples=%0d exp=0", bad); end
    $display("txn isolation samples=8");
  endtask

  task automatic test_reset_mid_grant();
    int who, n; bit ok;
    cs0_n = 0; sck0 = 0; mosi0 = 0; spi_miso = 0;
    #3 rst = 1'b1; #1;
    checks++; if ({spi_cs_n, gnt0, busy} !== 3'b100) begin failures++; $display("FAIL rst_async got=%b exp=100", {spi_cs_n, gnt0, busy}); end
    cs0_n = 1;
    tick(); tick();
    rst = 1'b0; exp_q.push_back(0);
    wait_rise(who, n, ok);
    checks++; if (!ok || who !== exp_q.pop_front() || n !== 1) begin failures++; $display("FAIL rst_regrant who=%0d n=%0d exp=0/1", who, n); end
    req0 = 0;
    wait_idle();
    $display("txn reset_mid_grant regrant_latency=%0d", n);
  endtask

  task automatic test_dirty_release();
    int who, n; bit ok;
    req1 = 1; exp_q.push_back(1);
    wait_rise(who, n, ok);
    checks++; if (!ok || who !== exp_q.pop_front()) begin failures++; $display("FAIL dirty_who got=%0d exp=1", who); end
    cs1_n = 0; #1;
    checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL dirty_cs_low got=%b exp=0", spi_cs_n); end
    req1 = 0; tick();
    checks++; if ({spi_cs_n, gnt1} !== 2'b10) begin failures++; $display("FAIL dirty_cs_forced got=%b exp=10", {spi_cs_n, gnt1}); end
    cs1_n = 1;
    wait_idle();
    $display("txn dirty_release spi_cs_n forced high");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_watchdog();
    test_isolation();
    test_reset_mid_grant();
    test_dirty_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp=finish");
    $fatal(1, "timeout");
  end

endmodule
